// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine for $4014 (OAMDMA): stalls the CPU and copies one
// 256-byte CPU page into PPU OAM through the OAMDATA register.

package ppu_defines_pkg;
    typedef enum logic [2:0] {
        PPUCTRL   = 3'd0,
        PPUMASK   = 3'd1,
        PPUSTATUS = 3'd2,
        OAMADDR   = 3'd3,
        OAMDATA   = 3'd4,
        PPUSCROLL = 3'd5,
        PPUADDR   = 3'd6,
        PPUDATA   = 3'd7
    } reg_t;
endpackage

module oam_dma_ctrl
    import ppu_defines_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_en,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_r_en,
    input  logic [7:0]  cpu_w_data,
    input  logic [7:0]  mem_r_data,
    output logic        dma_active,
    output logic        cpu_stall,
    output logic [15:0] dma_addr,
    output logic        dma_r_en,
    output logic        reg_en,
    output reg_t        reg_sel,
    output logic        reg_rw,
    output logic [7:0]  reg_data_wr,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       odd;
    logic [7:0] page;
    logic [7:0] idx;
    logic       trigger;
    logic       last_write;

    assign trigger    = (state == IDLE) && !cpu_r_en && (cpu_addr == 16'h4014);
    assign last_write = (state == WRITE) && (idx == 8'hFF);

    // odd tracks CPU cycle parity so that every READ lands on an even cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            odd      <= 1'b0;
            page     <= 8'h00;
            idx      <= 8'h00;
            dma_done <= 1'b0;
        end else if (clock_en) begin
            state    <= state_next;
            odd      <= ~odd;
            dma_done <= last_write;
            if (trigger) begin
                page <= cpu_w_data;
                idx  <= 8'h00;
            end else if ((state == WRITE) && !last_write) begin
                idx <= idx + 8'h01;
            end
        end
    end

    always_comb begin
        state_next  = state;
        cpu_stall   = 1'b0;
        dma_active  = 1'b0;
        dma_addr    = 16'h0000;
        dma_r_en    = 1'b1;
        reg_en      = 1'b0;
        reg_sel     = PPUCTRL;
        reg_rw      = 1'b0;
        reg_data_wr = 8'h00;
        case (state)
            IDLE: begin
                if (trigger)
                    state_next = HALT;
            end
            HALT: begin
                cpu_stall  = 1'b1;
                state_next = odd ? READ : ALIGN;
            end
            ALIGN: begin
                cpu_stall  = 1'b1;
                state_next = READ;
            end
            READ: begin
                cpu_stall  = 1'b1;
                dma_active = 1'b1;
                dma_addr   = {page, idx};
                state_next = WRITE;
            end
            WRITE: begin
                // memory data from the previous READ goes straight to OAMDATA
                cpu_stall   = 1'b1;
                dma_active  = 1'b1;
                reg_en      = 1'b1;
                reg_sel     = OAMDATA;
                reg_rw      = 1'b1;
                reg_data_wr = mem_r_data;
                state_next  = last_write ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: vector table for idle/trigger
// decoding plus hand-written full-transfer, reset and back-to-back sequences.

module tb_oam_dma_ctrl;
    import ppu_defines_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clock_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_r_en = 1'b1;
    logic [7:0]  cpu_w_data = 8'h00;
    logic [7:0]  mem_r_data = 8'h00;
    logic        dma_active;
    logic        cpu_stall;
    logic [15:0] dma_addr;
    logic        dma_r_en;
    logic        reg_en;
    reg_t        reg_sel;
    logic        reg_rw;
    logic [7:0]  reg_data_wr;
    logic        dma_done;

    int checks = 0;
    int errors = 0;
    bit tb_odd = 1'b0;

    oam_dma_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .clock_en    (clock_en),
        .cpu_addr    (cpu_addr),
        .cpu_r_en    (cpu_r_en),
        .cpu_w_data  (cpu_w_data),
        .mem_r_data  (mem_r_data),
        .dma_active  (dma_active),
        .cpu_stall   (cpu_stall),
        .dma_addr    (dma_addr),
        .dma_r_en    (dma_r_en),
        .reg_en      (reg_en),
        .reg_sel     (reg_sel),
        .reg_rw      (reg_rw),
        .reg_data_wr (reg_data_wr),
        .dma_done    (dma_done)
    );

    always #5 clock = ~clock;

    // RAM contents: byte = lo ^ hi ^ 8'h58, so page $02 holds i ^ 8'h5A
    function automatic logic [7:0] ram_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    always @(posedge clock) begin
        if (clock_en)
            mem_r_data <= ram_byte(dma_active ? dma_addr : cpu_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (clock_en && !reset)
            tb_odd = ~tb_odd;
        @(posedge clock);
        #1;
        if (reset)
            tb_odd = 1'b0;
    endtask

    task automatic setIdleInputs();
        cpu_addr   = 16'h0000;
        cpu_r_en   = 1'b1;
        cpu_w_data = 8'h00;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_stall"},  32'(cpu_stall),   32'd0);
        checkOutput({tag, "_active"}, 32'(dma_active),  32'd0);
        checkOutput({tag, "_addr"},   32'(dma_addr),    32'd0);
        checkOutput({tag, "_r_en"},   32'(dma_r_en),    32'd1);
        checkOutput({tag, "_reg_en"}, 32'(reg_en),      32'd0);
        checkOutput({tag, "_sel"},    32'(reg_sel),     32'(PPUCTRL));
        checkOutput({tag, "_rw"},     32'(reg_rw),      32'd0);
        checkOutput({tag, "_wdata"},  32'(reg_data_wr), 32'd0);
        checkOutput({tag, "_done"},   32'(dma_done),    32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic        ce;
        logic [15:0] addr;
        logic        r_en;
        logic [7:0]  wdata;
        logic        exp_stall;
        logic        exp_active;
        logic        exp_r_en;
        logic        exp_reg_en;
        logic        exp_done;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        clock_en   = v.ce;
        cpu_addr   = v.addr;
        cpu_r_en   = v.r_en;
        cpu_w_data = v.wdata;
        tick();
    endtask

    // Runs one transfer from its trigger edge to the dma_done cycle.
    // pretrig: trigger inputs were already set up in the previous done cycle.
    task automatic doTransfer(input logic [7:0] pg, input bit want_odd, input bit rand_ce,
                              input bit jam, input bit pretrig, input bit chain,
                              input logic [7:0] next_pg, input string tag);
        bit   odd_t1;
        bit   finished = 1'b0;
        int   k = 1;
        int   guard = 0;
        int   rd = 0;
        int   wr = 0;
        int   stall_cnt = 0;
        int   addr_bad = 0;
        int   data_bad = 0;
        int   first_read_k = -1;
        bit   first_read_odd = 1'b1;
        int   exp_stall;
        logic [7:0] exp_data;

        if (!pretrig) begin
            clock_en = 1'b1;
            setIdleInputs();
            if (~tb_odd != want_odd)
                tick();
            cpu_addr   = 16'h4014;
            cpu_r_en   = 1'b0;
            cpu_w_data = pg;
        end
        clock_en = 1'b1;
        odd_t1 = ~tb_odd;
        exp_stall = odd_t1 ? 513 : 514;
        tick();

        while (!finished && guard < 4000) begin
            guard++;
            clock_en = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
            if (jam) begin
                cpu_addr   = 16'h4014;
                cpu_r_en   = 1'b0;
                cpu_w_data = 8'hEE;
            end else begin
                setIdleInputs();
            end
            if (clock_en) begin
                if (cpu_stall)
                    stall_cnt++;
                if (dma_active && !reg_en) begin
                    if (first_read_k < 0) begin
                        first_read_k   = k;
                        first_read_odd = tb_odd;
                    end
                    if (dma_addr !== {pg, rd[7:0]})
                        addr_bad++;
                    rd++;
                end
                if (reg_en) begin
                    exp_data = wr[7:0] ^ pg ^ 8'h58;
                    if (reg_data_wr !== exp_data || reg_sel !== OAMDATA || reg_rw !== 1'b1)
                        data_bad++;
                    wr++;
                end
                if (dma_done) begin
                    finished = 1'b1;
                    checkOutput({tag, "_done_cycle"}, 32'(k), 32'(exp_stall + 1));
                    checkOutput({tag, "_stall_len"}, 32'(stall_cnt), 32'(exp_stall));
                    checkOutput({tag, "_stall_at_done"}, 32'(cpu_stall), 32'd0);
                    checkOutput({tag, "_reads"}, 32'(rd), 32'd256);
                    checkOutput({tag, "_writes"}, 32'(wr), 32'd256);
                    checkOutput({tag, "_addr_seq"}, 32'(addr_bad), 32'd0);
                    checkOutput({tag, "_data_seq"}, 32'(data_bad), 32'd0);
                    checkOutput({tag, "_first_read_k"}, 32'(first_read_k), odd_t1 ? 32'd2 : 32'd3);
                    checkOutput({tag, "_first_read_odd"}, 32'(first_read_odd), 32'd0);
                    if (chain) begin
                        cpu_addr   = 16'h4014;
                        cpu_r_en   = 1'b0;
                        cpu_w_data = next_pg;
                    end else begin
                        setIdleInputs();
                        tick();
                    end
                end
                k++;
            end
            if (!finished)
                tick();
        end
        if (!finished)
            checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        // rst ce addr r_en wdata | stall active r_en reg_en done
        vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h4015, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h4014, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'h4014, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h4013, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0200, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h4014, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        #12;
        checkResetOutputs("reset");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_stall", i),  32'(cpu_stall),  32'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_active", i), 32'(dma_active), 32'(vecs[i].exp_active));
            checkOutput($sformatf("vec%0d_r_en", i),   32'(dma_r_en),   32'(vecs[i].exp_r_en));
            checkOutput($sformatf("vec%0d_reg_en", i), 32'(reg_en),     32'(vecs[i].exp_reg_en));
            checkOutput($sformatf("vec%0d_done", i),   32'(dma_done),   32'(vecs[i].exp_done));
            checkOutput($sformatf("vec%0d_addr", i),   32'(dma_addr),   32'd0);
        end
        reset = 1'b0;
        setIdleInputs();
        clock_en = 1'b1;
        tick();

        doTransfer(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "odd_xfer");
        doTransfer(8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "even_xfer");
        doTransfer(8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "rand_ce_xfer");
        doTransfer(8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "jam_xfer");

        // Reset asserted asynchronously while writing idx 8'h40
        begin
            int  wr = 0;
            int  guard = 0;
            bit  hit = 1'b0;
            clock_en   = 1'b1;
            cpu_addr   = 16'h4014;
            cpu_r_en   = 1'b0;
            cpu_w_data = 8'h02;
            tick();
            setIdleInputs();
            while (!hit && guard < 2000) begin
                guard++;
                if (reg_en) begin
                    if (wr == 8'h40)
                        hit = 1'b1;
                    else
                        wr++;
                end
                if (!hit)
                    tick();
            end
            checkOutput("mid_reset_reached", 32'(hit), 32'd1);
            checkOutput("mid_reset_pre_data", 32'(reg_data_wr), 32'(8'h40 ^ 8'h5A));
            #2;
            reset = 1'b1;
            #1;
            tb_odd = 1'b0;
            checkResetOutputs("mid_reset");
            tick();
            reset = 1'b0;
        end
        doTransfer(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "post_reset_xfer");

        doTransfer(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, "b2b_first");
        doTransfer(8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "b2b_second");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
